// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: widths, funct3 codes, FSM states and
// the byte-count decode.
package mem_access_pkg;

    localparam int RegLen      = 32;
    localparam int RegAddrLen  = 5;
    localparam int AddrLen     = 32;
    localparam int OpCodeLen   = 4;
    localparam int PipelineNum = 6;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Index of the last byte of an access; the unused size code is treated as a word.
    function automatic logic [1:0] last_byte(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   last_byte = 2'd0;
            2'b01:   last_byte = 2'd1;
            default: last_byte = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide shared RAM port: the MEM stage is the master, the RAM arbiter the slave.
interface mem_access_if;
    import mem_access_pkg::*;

    logic               req;
    logic               gnt;
    logic [AddrLen-1:0] a;
    logic               wr;
    logic [7:0]         dout;
    logic [7:0]         din;

    modport master (output req, a, wr, dout, input gnt, din);
    modport slave  (input req, a, wr, dout, output gnt, din);

endinterface

// File: rtl/mem_access_load_ext.sv
// Load-data extension: selects the loaded width from the assembled bytes and
// sign- or zero-extends it according to funct3.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [RegLen-1:0] raw,
    input  logic [2:0]        funct3,
    output logic [RegLen-1:0] data
);

    always_comb begin
        data = raw;
        case (funct3)
            F3_LB:   data = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   data = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  data = {24'd0, raw[7:0]};
            F3_LHU:  data = {16'd0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: performs loads/stores one byte at a time over the shared
// RAM port. Optional macro MEM_ALIGN_TRAP_EN turns misaligned LH/LW/SH/SW into traps.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RegLen-1:0]      mem_rd_data,
    input  logic [RegAddrLen-1:0]  mem_rd_addr,
    input  logic                   mem_rd_enable,
    input  logic                   load_enable_i,
    input  logic                   store_enable_i,
    input  logic [AddrLen-1:0]     mem_addr_i,
    input  logic [OpCodeLen-1:0]   load_store_type_i,
    input  logic [PipelineNum-1:0] stall_i,
    mem_access_if.master           ram,
    output logic [RegLen-1:0]      wb_rd_data,
    output logic [RegAddrLen-1:0]  wb_rd_addr,
    output logic                   wb_rd_enable,
    output logic                   stall_req_o,
    output logic                   misalign_o
);

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic              cap_vld;
    logic [1:0]        cap_idx;
    logic [RegLen-1:0] lbuf;
    logic              mis_q, mis_nxt;
    logic [RegLen-1:0] ext_data;
    logic [2:0]        f3;
    logic [1:0]        last;
    logic              mem_op;
    logic              misaligned;
    logic              unused_ok;

    assign f3     = load_store_type_i[2:0];
    assign last   = last_byte(f3);
    assign mem_op = load_enable_i | store_enable_i;
    assign unused_ok = ^{load_store_type_i[3], stall_i[5:4], stall_i[2:0]};

`ifdef MEM_ALIGN_TRAP_EN
    assign misaligned = (f3[1:0] == 2'b01 && mem_addr_i[0]) ||
                        (f3[1:0] == 2'b10 && mem_addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    mem_load_ext u_ext (
        .raw    (lbuf),
        .funct3 (f3),
        .data   (ext_data)
    );

    // A granted read returns its byte one cycle later; capture it regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 2'd0;
            cap_vld <= 1'b0;
            cap_idx <= 2'd0;
            lbuf    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mis_q   <= mis_nxt;
            cap_vld <= (state == ST_ACCESS) && ram.gnt && !store_enable_i;
            cap_idx <= cnt;
            if (cap_vld) lbuf[{cap_idx, 3'b000} +: 8] <= ram.din;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        mis_nxt      = mis_q;
        ram.req      = 1'b0;
        ram.a        = mem_addr_i + AddrLen'(cnt);
        ram.wr       = 1'b0;
        ram.dout     = mem_rd_data[{cnt, 3'b000} +: 8];
        wb_rd_data   = mem_rd_data;
        wb_rd_addr   = mem_rd_addr;
        wb_rd_enable = mem_rd_enable;
        stall_req_o  = 1'b0;
        misalign_o   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    stall_req_o  = 1'b1;
                    wb_rd_enable = 1'b0;
                    cnt_nxt      = 2'd0;
                    mis_nxt      = misaligned;
                    state_nxt    = misaligned ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall_req_o  = 1'b1;
                wb_rd_enable = 1'b0;
                ram.req      = 1'b1;
                ram.wr       = store_enable_i;
                if (ram.gnt) begin
                    if (cnt == last) state_nxt = store_enable_i ? ST_DONE : ST_DRAIN;
                    else             cnt_nxt   = cnt + 2'd1;
                end
            end
            ST_DRAIN: begin
                stall_req_o  = 1'b1;
                wb_rd_enable = 1'b0;
                state_nxt    = ST_DONE;
            end
            ST_DONE: begin
                misalign_o = mis_q;
                if (store_enable_i || mis_q) begin
                    wb_rd_enable = 1'b0;
                end else begin
                    wb_rd_data   = ext_data;
                    wb_rd_enable = mem_rd_enable;
                end
                // The result stays up, without re-running the access, while EX/MEM holds.
                if (!stall_i[3]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (rst) begin
            ram.req      = 1'b0;
            ram.a        = '0;
            ram.wr       = 1'b0;
            ram.dout     = '0;
            wb_rd_data   = '0;
            wb_rd_addr   = '0;
            wb_rd_enable = 1'b0;
            stall_req_o  = 1'b0;
            misalign_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table over loads/stores/pass-through plus
// hand sequences for a denied grant, a held result and reset mid-store.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_rd_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_enable;
    logic        load_enable_i, store_enable_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  load_store_type_i;
    logic [5:0]  stall_i;
    logic [31:0] wb_rd_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_enable, stall_req_o, misalign_o;

    mem_access_if bus ();

    mem_access dut (
        .clk               (clk),
        .rst               (rst),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_enable     (mem_rd_enable),
        .load_enable_i     (load_enable_i),
        .store_enable_i    (store_enable_i),
        .mem_addr_i        (mem_addr_i),
        .load_store_type_i (load_store_type_i),
        .stall_i           (stall_i),
        .ram               (bus),
        .wb_rd_data        (wb_rd_data),
        .wb_rd_addr        (wb_rd_addr),
        .wb_rd_enable      (wb_rd_enable),
        .stall_req_o       (stall_req_o),
        .misalign_o        (misalign_o)
    );

    always #5 clk = ~clk;

    // RAM model: 1 KiB, read data registered one cycle after a granted read.
    logic [7:0] mem [0:1023];
    int xfers = 0;
    int wrs   = 0;
    always @(posedge clk) begin
        if (bus.req && bus.gnt) begin
            xfers++;
            if (bus.wr) begin
                mem[bus.a[9:0]] = bus.dout;
                wrs++;
            end else begin
                bus.din <= mem[bus.a[9:0]];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        ld, st;
        logic [31:0] addr, data;
        logic [4:0]  rd;
        logic        rd_en;
        logic [31:0] exp_data;
        logic        exp_en, chk_data, exp_mis;
        int          exp_cyc, exp_xfer;
    } vec_t;

    task automatic set_op(input vec_t v);
        load_store_type_i = {1'b0, v.f3};
        load_enable_i     = v.ld;
        store_enable_i    = v.st;
        mem_addr_i        = v.addr;
        mem_rd_data       = v.data;
        mem_rd_addr       = v.rd;
        mem_rd_enable     = v.rd_en;
    endtask

    task automatic set_nop(input logic [31:0] d, input logic [4:0] rd);
        load_store_type_i = 4'd0;
        load_enable_i     = 1'b0;
        store_enable_i    = 1'b0;
        mem_addr_i        = 32'd0;
        mem_rd_data       = d;
        mem_rd_addr       = rd;
        mem_rd_enable     = 1'b1;
    endtask

    // Applies an op after a rising edge and counts stalled cycles until DONE
    // (bounded); pat[k] is the grant offered in the k-th cycle of the op.
    task automatic run_op(input vec_t v, input logic [63:0] pat, output int cyc, output int nx);
        int x0;
        @(posedge clk); #1;
        x0 = xfers;
        set_op(v);
        bus.gnt = pat[0];
        cyc = 0;
        @(negedge clk);
        while (stall_req_o && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
            bus.gnt = pat[cyc];
            @(negedge clk);
        end
        nx = xfers - x0;
    endtask

    vec_t vecs [10];

    initial begin
        int cyc, nx, w0, x0;
        vec_t v;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h80;
        mem[10'h110] = 8'h34; mem[10'h111] = 8'h82;
        mem[10'h300] = 8'h44; mem[10'h301] = 8'h33; mem[10'h302] = 8'h22;
        mem[10'h303] = 8'h11; mem[10'h304] = 8'h66; mem[10'h305] = 8'h55;

        //         f3      ld    st    addr         data          rd  en    exp_data      en    chkd  mis   cyc xfer
        vecs[0] = '{F3_LB,  1'b0, 1'b0, 32'h0,       32'h1234,     5,  1'b1, 32'h1234,     1'b1, 1'b1, 1'b0, 0, 0};
        vecs[1] = '{F3_LB,  1'b1, 1'b0, 32'h100,     32'h0,        6,  1'b1, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 3, 1};
        vecs[2] = '{F3_LBU, 1'b1, 1'b0, 32'h100,     32'h0,        7,  1'b1, 32'h00000080, 1'b1, 1'b1, 1'b0, 3, 1};
        vecs[3] = '{F3_LH,  1'b1, 1'b0, 32'h110,     32'h0,        8,  1'b1, 32'hFFFF8234, 1'b1, 1'b1, 1'b0, 4, 2};
        vecs[4] = '{F3_LHU, 1'b1, 1'b0, 32'h110,     32'h0,        9,  1'b1, 32'h00008234, 1'b1, 1'b1, 1'b0, 4, 2};
        vecs[5] = '{F3_LW,  1'b1, 1'b0, 32'h300,     32'h0,        10, 1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0, 6, 4};
        vecs[6] = '{F3_SB,  1'b0, 1'b1, 32'h120,     32'hAABBCC5A, 11, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1};
        vecs[7] = '{F3_SH,  1'b0, 1'b1, 32'h130,     32'h0000F00D, 12, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 3, 2};
        vecs[8] = '{F3_LW,  1'b1, 1'b0, 32'h300,     32'h0,        13, 1'b0, 32'h11223344, 1'b0, 1'b1, 1'b0, 6, 4};
`ifdef MEM_ALIGN_TRAP_EN
        vecs[9] = '{F3_LW,  1'b1, 1'b0, 32'h302,     32'h0,        14, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1, 0};
`else
        vecs[9] = '{F3_LW,  1'b1, 1'b0, 32'h302,     32'h0,        14, 1'b1, 32'h55661122, 1'b1, 1'b1, 1'b0, 6, 4};
`endif

        // Reset with a load pending: every output must be forced low.
        rst = 1'b1;
        stall_i = 6'd0;
        bus.gnt = 1'b1;
        set_op(vecs[5]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_data",   wb_rd_data,   32'd0);
        chk("rst_wb_addr",   32'(wb_rd_addr), 32'd0);
        chk("rst_wb_en",     32'(wb_rd_enable), 32'd0);
        chk("rst_stall",     32'(stall_req_o), 32'd0);
        chk("rst_ram_req",   32'(bus.req), 32'd0);
        chk("rst_misalign",  32'(misalign_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop(32'd0, 5'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], '1, cyc, nx);
            if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), wb_rd_data, vecs[i].exp_data);
            chk($sformatf("v%0d_en", i),    32'(wb_rd_enable), 32'(vecs[i].exp_en));
            chk($sformatf("v%0d_addr", i),  32'(wb_rd_addr), 32'(vecs[i].rd));
            chk($sformatf("v%0d_cyc", i),   cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d_xfer", i),  nx, vecs[i].exp_xfer);
            chk($sformatf("v%0d_mis", i),   32'(misalign_o), 32'(vecs[i].exp_mis));
            chk($sformatf("v%0d_req", i),   32'(bus.req), 32'd0);
            @(posedge clk); #1;
            set_nop(32'd0, 5'd0);
        end
        chk("sb_byte0", 32'(mem[10'h120]), 32'h5A);
        chk("sb_byte1", 32'(mem[10'h121]), 32'h00);
        chk("sh_byte0", 32'(mem[10'h130]), 32'h0D);
        chk("sh_byte1", 32'(mem[10'h131]), 32'hF0);
        chk("sh_byte2", 32'(mem[10'h132]), 32'h00);

        // SW with the grant withheld on the second ACCESS cycle.
        w0 = wrs;
        v = '{F3_SW, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0};
        run_op(v, ~64'h4, cyc, nx);
        chk("sw_gap_cyc",  cyc, 6);
        chk("sw_gap_wrs",  wrs - w0, 4);
        chk("sw_gap_b0",   32'(mem[10'h200]), 32'hEF);
        chk("sw_gap_b1",   32'(mem[10'h201]), 32'hBE);
        chk("sw_gap_b2",   32'(mem[10'h202]), 32'hAD);
        chk("sw_gap_b3",   32'(mem[10'h203]), 32'hDE);
        @(posedge clk); #1;
        set_nop(32'd0, 5'd0);

        // LW completes while EX/MEM is held for three cycles.
        v = '{F3_LW, 1'b1, 1'b0, 32'h300, 32'h0, 3, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0};
        bus.gnt = 1'b1;
        run_op(v, '1, cyc, nx);
        chk("hold_cyc",  cyc, 6);
        chk("hold_data0", wb_rd_data, 32'h11223344);
        stall_i = 6'b001000;
        x0 = xfers;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold%0d_data", k),  wb_rd_data, 32'h11223344);
            chk($sformatf("hold%0d_en", k),    32'(wb_rd_enable), 32'd1);
            chk($sformatf("hold%0d_req", k),   32'(bus.req), 32'd0);
            chk($sformatf("hold%0d_stall", k), 32'(stall_req_o), 32'd0);
        end
        chk("hold_xfers", xfers - x0, 0);
        stall_i = 6'd0;
        @(posedge clk); #1;
        set_nop(32'hCAFE0001, 5'd17);
        @(negedge clk);
        chk("hold_rel_data",  wb_rd_data, 32'hCAFE0001);
        chk("hold_rel_addr",  32'(wb_rd_addr), 32'd17);
        chk("hold_rel_stall", 32'(stall_req_o), 32'd0);

        // Reset lands after the second SW byte: only two bytes reach RAM.
        v = '{F3_SW, 1'b0, 1'b1, 32'h210, 32'h01020304, 2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0};
        @(posedge clk); #1;
        w0 = wrs;
        bus.gnt = 1'b1;
        set_op(v);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstmid_req",   32'(bus.req), 32'd0);
        chk("rstmid_stall", 32'(stall_req_o), 32'd0);
        chk("rstmid_wb_en", 32'(wb_rd_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop(32'h00000042, 5'd9);
        @(negedge clk);
        chk("rstmid_wrs",   wrs - w0, 2);
        chk("rstmid_b0",    32'(mem[10'h210]), 32'h04);
        chk("rstmid_b1",    32'(mem[10'h211]), 32'h03);
        chk("rstmid_b2",    32'(mem[10'h212]), 32'h00);
        chk("rstmid_idle",  32'(stall_req_o), 32'd0);
        chk("rstmid_pass",  wb_rd_data, 32'h00000042);
        chk("rstmid_pass_en", 32'(wb_rd_enable), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
